// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, canonical special encodings and the
// operand classifier used by the divider and the multiplier.
package fp16_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_BIAS   = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp16_class_t;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} fp16_div_state_t;

  // Operand context captured when a divide is accepted
  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] ea;
    logic [FP16_EXP_W-1:0] eb;
    fp16_class_t           ca;
    fp16_class_t           cb;
  } fp16_op_t;

  // Subnormals (exp==0) are flushed and treated as zero
  function automatic fp16_class_t fp16_classify(input logic [15:0] x);
    logic [FP16_EXP_W-1:0]  e;
    logic [FP16_FRAC_W-1:0] f;
    e = x[14:10];
    f = x[9:0];
    if (e == '0)        return ZERO;
    else if (e == '1)   return (f == '0) ? INF : NAN;
    else                return NORMAL;
  endfunction

endpackage

// File: rtl/fp16_mant_divider.sv
// 11-bit radix-2 restoring mantissa divider: one quotient bit per step,
// MSB first, 12 steps from load to the final quotient.
module fp16_mant_divider
  import fp16_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic [FP16_FRAC_W-1:0] i_a_frac,
  input  logic [FP16_FRAC_W-1:0] i_b_frac,
  output logic                   o_last,
  output logic [11:0]            o_q
);

  logic [11:0] r_rem;
  logic [10:0] r_div;
  logic [11:0] r_q;
  logic [3:0]  r_cnt;

  logic        w_ge;
  logic [11:0] w_sub;

  assign w_ge   = r_rem >= {1'b0, r_div};
  assign w_sub  = r_rem - {1'b0, r_div};
  assign o_last = (r_cnt == 4'd0);
  assign o_q    = r_q;

  // Remainder stays below 2*div, so the shifted value always fits in 12 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= {2'b01, i_a_frac};
      r_div <= {1'b1, i_b_frac};
      r_q   <= '0;
      r_cnt <= 4'd11;
    end else if (i_step) begin
      if (w_ge) begin
        r_q[r_cnt] <= 1'b1;
        r_rem      <= {w_sub[10:0], 1'b0};
      end else begin
        r_rem      <= {r_rem[10:0], 1'b0};
      end
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/floating_point_divider.sv
// FP16 divider (a / b): truncating, flush-to-zero, saturating exponent,
// fixed 13-cycle start-to-ready latency.
module floating_point_divider
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero
);

  generate
    if (DATA_WIDTH != 16) begin : g_bad_width
      $error("floating_point_divider supports DATA_WIDTH=16 only");
    end
  endgenerate

  fp16_div_state_t r_state;
  fp16_op_t        r_op;
  logic            r_busy;
  logic            r_ready;
  logic [15:0]     r_result;
  logic            r_dbz;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [11:0]       w_q;
  logic signed [6:0] w_e;
  logic [9:0]        w_frac;
  logic [15:0]       w_res;
  logic              w_dbz;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_DIV);

  fp16_mant_divider u_mant (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a_frac (a[9:0]),
    .i_b_frac (b[9:0]),
    .o_last   (w_last),
    .o_q      (w_q)
  );

  // Quotient lies in (0.5, 2): q[11] tells whether a one-bit renormalise is needed
  assign w_frac = w_q[11] ? w_q[10:1] : w_q[9:0];
  assign w_e    = $signed({2'b00, r_op.ea}) - $signed({2'b00, r_op.eb})
                + (w_q[11] ? 7'(FP16_BIAS) : 7'(FP16_BIAS - 1));

  always_comb begin
    w_res = '0;
    w_dbz = 1'b0;
    if (w_e <= 7'sd0)       w_res = {r_op.sign, 15'h0000};
    else if (w_e >= 7'sd31) w_res = {r_op.sign, FP16_INF[14:0]};
    else                    w_res = {r_op.sign, w_e[4:0], w_frac};

    if (r_op.ca == NAN || r_op.cb == NAN) begin
      w_res = FP16_QNAN;
    end else if ((r_op.ca == INF && r_op.cb == INF) ||
                 (r_op.ca == ZERO && r_op.cb == ZERO)) begin
      w_res = FP16_QNAN;
    end else if (r_op.ca == NORMAL && r_op.cb == ZERO) begin
      w_res = {r_op.sign, FP16_INF[14:0]};
      w_dbz = 1'b1;
    end else if (r_op.ca == INF) begin
      w_res = {r_op.sign, FP16_INF[14:0]};
    end else if (r_op.cb == INF || r_op.ca == ZERO) begin
      w_res = {r_op.sign, 15'h0000};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op.sign <= a[15] ^ b[15];
          r_op.ea   <= a[14:10];
          r_op.eb   <= b[14:10];
          r_op.ca   <= fp16_classify(a);
          r_op.cb   <= fp16_classify(b);
          r_busy    <= 1'b1;
          r_state   <= S_DIV;
        end
        S_DIV: if (w_last) r_state <= S_NORM;
        S_NORM: begin
          r_result <= w_res;
          r_dbz    <= w_dbz;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign ready       = r_ready;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed bench for floating_point_divider: expected results are queued on
// issue and checked by a monitor whenever ready pulses.
module tb_floating_point_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, ready, div_by_zero;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] sb_q[$];

  floating_point_divider #(.DATA_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .ready       (ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest queued result
  always @(negedge clk) begin
    if (!reset && ready) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_errors++;
        $error("FAIL spurious_ready: observed ready=1 expected no pending op");
      end
      if (sb_q.size() != 0) begin
        logic [16:0] e;
        e = sb_q.pop_front();
        chk("result", result, e[16:1]);
        chk("div_by_zero", {15'h0, div_by_zero}, {15'h0, e[0]});
      end
    end
  end

  // Call at a negedge; returns at the negedge following the accepting edge
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] er, input logic ed, input bit track);
    a = ia; b = ib; start = 1'b1;
    if (track) sb_q.push_back({er, ed});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges since acceptance until ready is seen, bounded
  task automatic wait_ready(input int n0, output int n);
    n = n0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input logic [15:0] ia, input logic [15:0] ib,
                    input logic [15:0] er, input logic ed, input string tag);
    int n;
    @(negedge clk);
    issue(ia, ib, er, ed, 1'b1);
    wait_ready(0, n);
    chk(tag, 16'(n), 16'd13);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_ready", {15'h0, ready}, 16'h0);
    chk("rst_result", result, 16'h0000);
    chk("rst_dbz", {15'h0, div_by_zero}, 16'h0);
    reset = 1'b0;

    op(16'h4000, 16'h3C00, 16'h4000, 1'b0, "lat_2div1");
    @(negedge clk);
    chk("ready_drops", {15'h0, ready}, 16'h0);
    op(16'h3C00, 16'h4200, 16'h3555, 1'b0, "lat_1div3");
    op(16'h3E00, 16'h4000, 16'h3A00, 1'b0, "lat_1p5div2");
    op(16'hC500, 16'h4100, 16'hC000, 1'b0, "lat_neg");
    op(16'h0000, 16'hC000, 16'h8000, 1'b0, "lat_zero_num");
    op(16'h3C00, 16'h0000, 16'h7C00, 1'b1, "lat_dbz");
    op(16'hBC00, 16'h0000, 16'hFC00, 1'b1, "lat_neg_dbz");
    op(16'h0000, 16'h0000, 16'h7E00, 1'b0, "lat_0div0");
    op(16'h7E01, 16'h3C00, 16'h7E00, 1'b0, "lat_nan");
    op(16'h7C00, 16'h7C00, 16'h7E00, 1'b0, "lat_infinf");
    op(16'h7C00, 16'h0000, 16'h7C00, 1'b0, "lat_inf_div0");
    op(16'h7C00, 16'hC000, 16'hFC00, 1'b0, "lat_inf_fin");
    op(16'h4000, 16'h7C00, 16'h0000, 1'b0, "lat_fin_inf");
    op(16'h0001, 16'h3C00, 16'h0000, 1'b0, "lat_subnorm");
    op(16'h7BFF, 16'h0400, 16'h7C00, 1'b0, "lat_ovf");
    op(16'h0400, 16'h7BFF, 16'h0000, 1'b0, "lat_unf");

    // start with new operands at cycle 5 of an op is ignored
    @(negedge clk);
    issue(16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_mid", {15'h0, busy}, 16'h1);
    a = 16'h3C00; b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(5, n);
    chk("lat_ignored_start", 16'(n), 16'd13);

    // back-to-back: start in the ready cycle
    @(negedge clk);
    issue(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b1);
    wait_ready(0, n);
    chk("lat_b2b_first", 16'(n), 16'd13);
    issue(16'hC500, 16'h4100, 16'hC000, 1'b0, 1'b1);
    wait_ready(0, n);
    chk("lat_b2b_second", 16'(n), 16'd13);

    // reset at cycle 6 aborts the op; no ready afterwards
    @(negedge clk);
    issue(16'h3E00, 16'h4000, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {15'h0, busy}, 16'h0);
    chk("abort_ready", {15'h0, ready}, 16'h0);
    chk("abort_result", result, 16'h0000);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready) n++;
    end
    chk("abort_no_ready", 16'(n), 16'd0);

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
